instruction_cache: RTL and testbench
====================================

// Module: instruction_cache
// PURPOSE
//  Direct-mapped, word-per-line instruction cache between Fetcher and MemoryController.
//  Serves Fetcher word reads from local storage on a hit. On a miss it issues a
//  single-word request to MemoryController, fills the line and returns the word.
//  Aborts an outstanding miss on ROB rollback. Read-only: there is no store or invalidate path.
// PARAMETERS
//  INDEX_WIDTH  8   line count = 2**INDEX_WIDTH; index = addr[INDEX_WIDTH+1:2]
//  ADDR_WIDTH   32  address width; tag = addr[ADDR_WIDTH-1:INDEX_WIDTH+2]
// PORTS
//  clk                  in   1   single clock, all state on posedge
//  rst                  in   1   synchronous, active-low reset (0 = reset)
//  rob_rollback_in      in   1   misprediction flush; aborts in-flight miss
//  fet_request_in       in   1   level request from Fetcher
//  fet_address_in       in   32  fetch PC; bits[1:0] ignored
//  fet_ready_out        out  1   one-cycle pulse, instruction valid
//  fet_instruction_out  out  32  returned instruction word
//  mc_ready_in          in   1   MemoryController word ready (one-cycle pulse)
//  mc_instruction_in    in   32  word from MemoryController
//  mc_request_out       out  1   level request to MemoryController
//  mc_address_out       out  32  word-aligned miss address
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - all valid bits cleared; state=IDLE
//   - fet_ready_out=0, fet_instruction_out=0, mc_request_out=0, mc_address_out=0
//  States:
//   - IDLE: accept a request.
//   - MISS: wait for MemoryController.
//  IDLE, fet_request_in=1, fet_ready_out=0 (a request is ignored in the cycle its response pulses):
//   - hit (valid[idx] && tag match): next cycle fet_ready_out=1, fet_instruction_out=data[idx];
//     stay IDLE. Hit latency = 1 cycle.
//   - miss: latch addr & ~3; next cycle mc_request_out=1, mc_address_out=latched addr;
//     state -> MISS.
//  MISS:
//   - mc_request_out is held high until mc_ready_in.
//   - On mc_ready_in: write data/tag, set valid[idx]; mc_request_out=0.
//   - The next cycle: fet_ready_out=1, fet_instruction_out=mc_instruction_in; state -> IDLE.
//   - fet_request_in and fet_address_in are not re-sampled while in MISS.
//  fet_ready_out is high for exactly one cycle per served request. Otherwise it is 0;
//   fet_instruction_out holds its last value.
//  Rollback (rob_rollback_in=1), priority over all other events that cycle:
//   - next cycle fet_ready_out=0, mc_request_out=0, state=IDLE.
//   - mc_ready_in in the same cycle: the line is still filled (data is true memory
//     content), but no fet_ready_out is produced.
//   - A pending hit response scheduled for the next cycle is suppressed.
//   - Fetcher re-requests from the rollback PC in a later cycle.
//  mc_ready_in while IDLE is ignored and performs no fill.
//  Fetcher request dropped while MISS: the fill still completes and fet_ready_out still
//   pulses; Fetcher ignores it.
//  Index wrap: addresses differing only in tag conflict; the newer fill overwrites
//   (no replacement state).
//  Reset mid-miss: discard everything, mc_request_out=0 in the following cycle.
// STRUCTURE
//  - Shared header gains: ICACHE_INDEX_WIDTH, ICACHE_TAG_RANGE, ICACHE_INDEX_RANGE,
//    state encodings ICACHE_IDLE / ICACHE_MISS. It reuses WORD_RANGE.
//  - One sub-module, icache_line_array: valid/tag/data storage.
//    - Combinational read on index.
//    - Synchronous write port.
//    - Synchronous valid clear on rst==0.
//  - Top level holds the FSM, latched miss address and output registers.
// TESTING
//  1 Cold miss: reset, req 0x0000_0100; MC ready after 4 cycles with 0x0000_0013
//    -> mc_request_out high 0x100 until ready; fet_ready_out pulse 1 cycle later, data 0x13.
//  2 Hit: repeat req 0x100 -> fet_ready_out next cycle, data 0x13, mc_request_out stays 0.
//  3 Conflict: req 0x100+(4<<INDEX_WIDTH)=0x500 -> miss, fill 0xDEADBEEF; req 0x100
//    -> miss again.
//  4 Rollback mid-miss: req 0x200, rollback 2 cycles later -> mc_request_out 0 next
//    cycle, no fet_ready_out pulse, state IDLE.
//  5 Rollback coincident with mc_ready_in (0x200, data 0x55) -> no pulse; later req
//    0x200 hits with 0x55.
//  6 Reset (rst=0) mid-miss, then req 0x100 -> miss (valid cleared), all outputs 0
//    during reset.

Source files
------------

// File: rtl/instruction_cache_pkg.sv
// Shared instruction cache constants: geometry, address field bounds, FSM codes.
// Imported by the cache top level and its line storage.
package instruction_cache_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int WORD_MSB   = WORD_WIDTH - 1;
  localparam int WORD_LSB   = 0;

  localparam int ICACHE_INDEX_WIDTH = 8;
  localparam int ICACHE_ADDR_WIDTH  = 32;

  localparam int ICACHE_INDEX_LSB = 2;
  localparam int ICACHE_INDEX_MSB = ICACHE_INDEX_WIDTH + 1;
  localparam int ICACHE_TAG_LSB   = ICACHE_INDEX_WIDTH + 2;
  localparam int ICACHE_TAG_MSB   = ICACHE_ADDR_WIDTH - 1;

  localparam logic [0:0] ICACHE_IDLE = 1'b0;
  localparam logic [0:0] ICACHE_MISS = 1'b1;

  typedef logic [WORD_MSB:WORD_LSB] word_t;

endpackage

// File: rtl/instruction_cache_line_array.sv
// Direct-mapped line storage: valid/tag/data per index.
// Combinational read, synchronous write, synchronous valid clear.
module icache_line_array
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = ICACHE_TAG_MSB - ICACHE_TAG_LSB + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output word_t                  rd_data,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  word_t                  wr_data
);

  localparam int LINES = 2 ** INDEX_WIDTH;

  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tags [LINES];
  word_t                data [LINES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped word-per-line instruction cache between Fetcher and
// MemoryController, with rollback abort of an outstanding miss.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rob_rollback_in,
  input  logic                  fet_request_in,
  input  logic [ADDR_WIDTH-1:0] fet_address_in,
  output logic                  fet_ready_out,
  output word_t                 fet_instruction_out,
  input  logic                  mc_ready_in,
  input  word_t                 mc_instruction_in,
  output logic                  mc_request_out,
  output logic [ADDR_WIDTH-1:0] mc_address_out
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  logic [0:0]             state;
  logic [ADDR_WIDTH-1:0]  fet_aligned;
  logic [INDEX_WIDTH-1:0] fet_index;
  logic [TAG_WIDTH-1:0]   fet_tag;
  logic [INDEX_WIDTH-1:0] miss_index;
  logic [TAG_WIDTH-1:0]   miss_tag;
  logic                   rd_valid;
  logic [TAG_WIDTH-1:0]   rd_tag;
  word_t                  rd_data;
  logic                   hit;
  logic                   fill;

  assign fet_aligned = fet_address_in & ALIGN_MASK;
  assign fet_index   = fet_aligned[INDEX_WIDTH+1:2];
  assign fet_tag     = fet_aligned[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign miss_index  = mc_address_out[INDEX_WIDTH+1:2];
  assign miss_tag    = mc_address_out[ADDR_WIDTH-1:INDEX_WIDTH+2];

  assign hit = rd_valid && (rd_tag == fet_tag);

  // Fill is independent of rollback: returned data is real memory content.
  assign fill = rst && (state == ICACHE_MISS) && mc_ready_in;

  icache_line_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_index (fet_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_index (miss_index),
    .wr_tag   (miss_tag),
    .wr_data  (mc_instruction_in)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= ICACHE_IDLE;
      fet_ready_out       <= 1'b0;
      fet_instruction_out <= '0;
      mc_request_out      <= 1'b0;
      mc_address_out      <= '0;
    end else if (rob_rollback_in) begin
      state          <= ICACHE_IDLE;
      fet_ready_out  <= 1'b0;
      mc_request_out <= 1'b0;
    end else begin
      fet_ready_out <= 1'b0;
      unique case (1'b1)
        state == ICACHE_IDLE: begin
          // A request seen while its response pulses is the same fetch.
          if (fet_request_in && !fet_ready_out) begin
            if (hit) begin
              fet_ready_out       <= 1'b1;
              fet_instruction_out <= rd_data;
            end else begin
              mc_address_out <= fet_aligned;
              mc_request_out <= 1'b1;
              state          <= ICACHE_MISS;
            end
          end
        end
        state == ICACHE_MISS: begin
          if (mc_ready_in) begin
            mc_request_out      <= 1'b0;
            fet_ready_out       <= 1'b1;
            fet_instruction_out <= mc_instruction_in;
            state               <= ICACHE_IDLE;
          end
        end
        default: state <= ICACHE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: scoreboarded fetch responses
// plus cycle-exact checks of the MemoryController handshake.
module tb_instruction_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rob_rollback_in;
  logic        fet_request_in;
  logic [31:0] fet_address_in;
  logic        fet_ready_out;
  logic [31:0] fet_instruction_out;
  logic        mc_ready_in;
  logic [31:0] mc_instruction_in;
  logic        mc_request_out;
  logic [31:0] mc_address_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  instruction_cache dut (
    .clk                 (clk),
    .rst                 (rst),
    .rob_rollback_in     (rob_rollback_in),
    .fet_request_in      (fet_request_in),
    .fet_address_in      (fet_address_in),
    .fet_ready_out       (fet_ready_out),
    .fet_instruction_out (fet_instruction_out),
    .mc_ready_in         (mc_ready_in),
    .mc_instruction_in   (mc_instruction_in),
    .mc_request_out      (mc_request_out),
    .mc_address_out      (mc_address_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every fetch response is matched against the scoreboard.
  always @(negedge clk) begin
    if (fet_ready_out === 1'b1) begin
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("fet_instruction", fet_instruction_out, exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(fet_ready_out), 32'd0);
    check({tag, "_mcreq"}, 32'(mc_request_out), 32'd0);
  endtask

  task automatic miss_fill(input logic [31:0] addr, input logic [31:0] data,
                           input int wait_cycles);
    fet_request_in = 1'b1;
    fet_address_in = addr;
    tick;
    fet_request_in = 1'b0;
    check("miss_mcreq", 32'(mc_request_out), 32'd1);
    check("miss_mcaddr", mc_address_out, addr & 32'hFFFF_FFFC);
    check("miss_noready", 32'(fet_ready_out), 32'd0);
    for (int i = 0; i < wait_cycles; i++) begin
      tick;
      check("miss_hold", 32'(mc_request_out), 32'd1);
    end
    mc_ready_in       = 1'b1;
    mc_instruction_in = data;
    exp_q.push_back(data);
    tick;
    mc_ready_in = 1'b0;
    check("fill_mcreq", 32'(mc_request_out), 32'd0);
    check("fill_ready", 32'(fet_ready_out), 32'd1);
    tick;
    check("fill_pulse_end", 32'(fet_ready_out), 32'd0);
  endtask

  task automatic hit(input logic [31:0] addr, input logic [31:0] data);
    fet_request_in = 1'b1;
    fet_address_in = addr;
    exp_q.push_back(data);
    tick;
    fet_request_in = 1'b0;
    check("hit_ready", 32'(fet_ready_out), 32'd1);
    check("hit_mcreq", 32'(mc_request_out), 32'd0);
    tick;
    check("hit_pulse_end", 32'(fet_ready_out), 32'd0);
  endtask

  initial begin
    rst               = 1'b0;
    rob_rollback_in   = 1'b0;
    fet_request_in    = 1'b0;
    fet_address_in    = '0;
    mc_ready_in       = 1'b0;
    mc_instruction_in = '0;
    tick;
    tick;
    check_idle_outputs("reset");
    check("reset_instr", fet_instruction_out, 32'h0);
    check("reset_mcaddr", mc_address_out, 32'h0);
    rst = 1'b1;
    tick;

    // cold miss then hit
    miss_fill(32'h0000_0100, 32'h0000_0013, 4);
    hit(32'h0000_0100, 32'h0000_0013);
    hit(32'h0000_0103, 32'h0000_0013);

    // conflicting tag evicts the line
    miss_fill(32'h0000_0500, 32'hDEAD_BEEF, 2);
    hit(32'h0000_0500, 32'hDEAD_BEEF);
    miss_fill(32'h0000_0100, 32'h0000_0013, 1);
    hit(32'h0000_0100, 32'h0000_0013);

    // rollback mid-miss
    fet_request_in = 1'b1;
    fet_address_in = 32'h0000_0200;
    tick;
    fet_request_in = 1'b0;
    check("rb_miss_mcreq", 32'(mc_request_out), 32'd1);
    tick;
    rob_rollback_in = 1'b1;
    tick;
    rob_rollback_in = 1'b0;
    check_idle_outputs("rb_abort");
    tick;
    check_idle_outputs("rb_after");

    // stray MC ready while idle must not fill
    mc_ready_in       = 1'b1;
    mc_instruction_in = 32'h0000_0077;
    tick;
    mc_ready_in = 1'b0;
    check_idle_outputs("idle_mcready");

    // rollback coincident with the fill
    fet_request_in = 1'b1;
    fet_address_in = 32'h0000_0200;
    tick;
    fet_request_in = 1'b0;
    check("rbfill_mcreq", 32'(mc_request_out), 32'd1);
    check("rbfill_mcaddr", mc_address_out, 32'h0000_0200);
    tick;
    mc_ready_in       = 1'b1;
    mc_instruction_in = 32'h0000_0055;
    rob_rollback_in   = 1'b1;
    tick;
    mc_ready_in     = 1'b0;
    rob_rollback_in = 1'b0;
    check_idle_outputs("rbfill");
    tick;
    check_idle_outputs("rbfill_after");
    hit(32'h0000_0200, 32'h0000_0055);

    // rollback suppresses a hit in the same cycle
    fet_request_in  = 1'b1;
    fet_address_in  = 32'h0000_0100;
    rob_rollback_in = 1'b1;
    tick;
    fet_request_in  = 1'b0;
    rob_rollback_in = 1'b0;
    check_idle_outputs("rb_hit");
    tick;
    check_idle_outputs("rb_hit_after");

    // reset during a miss
    fet_request_in = 1'b1;
    fet_address_in = 32'h0000_0600;
    tick;
    fet_request_in = 1'b0;
    check("rst_miss_mcreq", 32'(mc_request_out), 32'd1);
    rst = 1'b0;
    tick;
    check_idle_outputs("rst_mid");
    check("rst_mid_instr", fet_instruction_out, 32'h0);
    check("rst_mid_mcaddr", mc_address_out, 32'h0);
    tick;
    check_idle_outputs("rst_mid2");
    rst = 1'b1;
    tick;
    miss_fill(32'h0000_0100, 32'h0000_0013, 0);
    hit(32'h0000_0100, 32'h0000_0013);

    tick;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
